// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: shared command opcodes, FSM states and counter width for the command sequencer
package counter_ctrl_pkg;
  localparam int CNT_W = 16;
  typedef enum logic [1:0] {OP_LOAD, OP_UP, OP_DOWN, OP_SEEK} cmd_op_e;
  typedef enum logic [2:0] {IDLE, LOAD, STEP, SEEK_ISSUE, SEEK_WAIT, DONE} state_e;
endpackage

// File: rtl/counter_cmd_ctrl.sv
// counter_cmd_ctrl: sequences LOAD/COUNT/SEEK commands onto the up/down counter control pins
module counter_cmd_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic [WIDTH-1:0] cnt_q,
  output logic [WIDTH-1:0] data_in,
  output logic             ld_cnt,
  output logic             updn_cnt,
  output logic             count_enb,
  output logic             busy,
  output logic             done
);
  localparam logic [WIDTH-1:0] LAST_STEP = {{(WIDTH-1){1'b0}}, 1'b1};
  state_e           r_state, w_nxt;
  cmd_op_e          r_op, w_op;
  logic [WIDTH-1:0] r_arg, r_rem, w_rem_nxt, w_data_nxt;
  logic             w_accept, w_ld_nxt, w_enb_nxt, w_updn_nxt, w_seek_eq;
  assign w_op      = cmd_op_e'(cmd_op);
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_seek_eq = cnt_q == r_arg;
  // Control outputs are registered from the next state so the counter sees
  // them one edge later; SEEK_WAIT therefore always compares a settled cnt_q.
  always_comb begin
    w_nxt      = r_state;
    w_ld_nxt   = 1'b1;
    w_enb_nxt  = 1'b0;
    w_updn_nxt = updn_cnt;
    w_data_nxt = data_in;
    w_rem_nxt  = r_rem;
    case (r_state)
      IDLE: if (w_accept) begin
        case (w_op)
          OP_LOAD: begin
            w_nxt      = LOAD;
            w_ld_nxt   = 1'b0;
            w_data_nxt = cmd_arg;
          end
          OP_UP, OP_DOWN: begin
            w_nxt      = (cmd_arg == '0) ? DONE : STEP;
            w_enb_nxt  = cmd_arg != '0;
            w_updn_nxt = w_op == OP_UP;
            w_rem_nxt  = cmd_arg;
          end
          default: w_nxt = SEEK_WAIT;
        endcase
      end
      LOAD: w_nxt = DONE;
      STEP: begin
        w_nxt      = (r_rem == LAST_STEP) ? DONE : STEP;
        w_enb_nxt  = r_rem != LAST_STEP;
        w_updn_nxt = r_op == OP_UP;
        w_rem_nxt  = r_rem - 1'b1;
      end
      SEEK_WAIT: begin
        w_nxt      = w_seek_eq ? DONE : SEEK_ISSUE;
        w_enb_nxt  = !w_seek_eq;
        w_updn_nxt = w_seek_eq ? updn_cnt : (cnt_q < r_arg);
      end
      SEEK_ISSUE: w_nxt = SEEK_WAIT;
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_state   <= IDLE;
      r_op      <= OP_LOAD;
      r_arg     <= '0;
      r_rem     <= '0;
      data_in   <= '0;
      ld_cnt    <= 1'b1;
      updn_cnt  <= 1'b1;
      count_enb <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      r_state   <= w_nxt;
      r_rem     <= w_rem_nxt;
      data_in   <= w_data_nxt;
      ld_cnt    <= w_ld_nxt;
      updn_cnt  <= w_updn_nxt;
      count_enb <= w_enb_nxt;
      busy      <= w_nxt != IDLE;
      done      <= w_nxt == DONE;
      cmd_ready <= w_nxt == IDLE;
      if (w_accept) begin
        r_op  <= w_op;
        r_arg <= cmd_arg;
      end
    end
  end
endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// tb_counter_cmd_ctrl: scoreboard bench driving commands into the sequencer with a behavioural counter on its pins
module tb_counter_cmd_ctrl;
  import counter_ctrl_pkg::*;
  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [15:0] cmd_arg = 16'h0;
  logic [15:0] cnt_q, data_in, q;
  logic        cmd_ready, ld_cnt, updn_cnt, count_enb, busy, done;
  always #5 clk = ~clk;
  counter_cmd_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst_(rst_), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cnt_q(cnt_q), .data_in(data_in),
    .ld_cnt(ld_cnt), .updn_cnt(updn_cnt), .count_enb(count_enb),
    .busy(busy), .done(done)
  );
  // stand-in for the downstream counter: load beats count, reset clears
  assign cnt_q = q;
  always @(posedge clk)
    if (!rst_) q <= 16'h0;
    else if (!ld_cnt) q <= data_in;
    else if (count_enb) q <= updn_cnt ? q + 16'd1 : q - 16'd1;
  int cyc = 0, n_enb = 0, n_up = 0, n_ld = 0, n_conf = 0, n_done = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (count_enb) n_enb <= n_enb + 1;
    if (count_enb && updn_cnt) n_up <= n_up + 1;
    if (!ld_cnt) n_ld <= n_ld + 1;
    if (!ld_cnt && count_enb) n_conf <= n_conf + 1;
    if (done) n_done <= n_done + 1;
  end
  typedef struct {
    string       tag;
    int          acc, lat, enb, up, ld, b_enb, b_up, b_ld;
    logic [15:0] q;
  } exp_t;
  exp_t sb[$];
  int n_tests = 0, n_fail = 0, n_pops = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic issue(input string tag, input cmd_op_e op, input logic [15:0] arg,
                       input int lat, input logic [15:0] eq, input int enb, input int up, input int ld);
    exp_t e;
    int   t = 0;
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    e.tag = tag; e.acc = cyc; e.lat = lat; e.q = eq; e.enb = enb; e.up = up; e.ld = ld;
    e.b_enb = n_enb; e.b_up = n_up; e.b_ld = n_ld;
    sb.push_back(e);
  endtask
  task automatic wait_done();
    exp_t e;
    int   t = 0;
    @(negedge clk);
    while (!done && t < 400) begin
      @(negedge clk);
      t++;
    end
    e = sb.pop_front();
    n_pops++;
    if (!done) chk({e.tag, "_timeout"}, 32'd0, 32'd1);
    else begin
      chk({e.tag, "_lat"}, cyc - e.acc + 1, e.lat);
      chk({e.tag, "_q"}, q, e.q);
      chk({e.tag, "_enb"}, n_enb - e.b_enb, e.enb);
      chk({e.tag, "_up"}, n_up - e.b_up, e.up);
      chk({e.tag, "_ld"}, n_ld - e.b_ld, e.ld);
    end
  endtask
  initial begin
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    cmd_arg   = 16'hABCD;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ld", ld_cnt, 1);
    chk("rst_enb", count_enb, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_data", data_in, 0);
    chk("rst_updn", updn_cnt, 1);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
    chk("rst_noacc_busy", busy, 0);
    chk("rst_noacc_q", q, 0);
    issue("load1234", OP_LOAD, 16'h1234, 2, 16'h1234, 0, 0, 1); wait_done();
    issue("loadfffe", OP_LOAD, 16'hFFFE, 2, 16'hFFFE, 0, 0, 1); wait_done();
    issue("up3wrap", OP_UP, 16'd3, 4, 16'h0001, 3, 3, 0); wait_done();
    issue("down0", OP_DOWN, 16'd0, 1, 16'h0001, 0, 0, 0); wait_done();
    issue("load10", OP_LOAD, 16'd10, 2, 16'd10, 0, 0, 1); wait_done();
    issue("seek7", OP_SEEK, 16'd7, 8, 16'd7, 3, 0, 0); wait_done();
    issue("seek9", OP_SEEK, 16'd9, 6, 16'd9, 2, 2, 0); wait_done();
    issue("seek9eq", OP_SEEK, 16'd9, 2, 16'd9, 0, 0, 0); wait_done();
    issue("load0", OP_LOAD, 16'd0, 2, 16'd0, 0, 0, 1); wait_done();
    issue("down2wrap", OP_DOWN, 16'd2, 3, 16'hFFFE, 2, 0, 0); wait_done();
    issue("seekffff", OP_SEEK, 16'hFFFF, 4, 16'hFFFF, 1, 1, 0); wait_done();
    issue("up100", OP_UP, 16'd100, 101, 16'd0, 0, 0, 0);
    begin
      int t = 0;
      while (n_enb - sb[0].b_enb < 20 && t < 200) begin
        @(negedge clk);
        t++;
      end
      chk("abort_reached", (n_enb - sb[0].b_enb >= 20) ? 1 : 0, 1);
    end
    rst_ = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    chk("abort_enb", count_enb, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_ld", ld_cnt, 1);
    chk("abort_q", q, 0);
    @(negedge clk);
    rst_ = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_idle_enb", count_enb, 0);
    chk("abort_idle_q", q, 0);
    issue("load5", OP_LOAD, 16'd5, 2, 16'd5, 0, 0, 1); wait_done();
    repeat (3) @(negedge clk);
    chk("done_count", n_done, n_pops);
    chk("ld_enb_excl", n_conf, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
